// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counting timer.
//   - register offsets decoded from addr[3:2]
//   - FSM state encoding
//   - MODE codes and CTRL bit indices
// No ports; imported by timer_counter.
package timer_counter_pkg;

   localparam int CNT_W_DEF  = 32;
   localparam int CTRL_W_DEF = 4;

   // Register offsets (word index within the 16-byte window)
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;

   // CTRL bit indices
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   // MODE codes; 2'b1x is treated as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer (bridge responder).
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   addr   in   [31:0] bridge address; only addr[3:2] decoded
//   we     in   word write enable, already range-qualified by the bridge
//   wdata  in   [31:0] write data
//   rdata  out  [31:0] combinational read of the selected register
//   irq    out  interrupt request = irq_flag & CTRL.IM
// Bus protocol: there is no valid/ready handshake. A write is accepted on
// every rising edge where we=1; reads are purely combinational from addr
// and never stall or have side effects.
module timer_counter
   import timer_counter_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   tc_state_e         state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  preset_q, preset_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              flag_q, flag_d;

   logic       en;
   logic       auto_reload;
   logic [1:0] reg_sel;

   assign reg_sel     = addr[3:2];
   assign en          = ctrl_q[CTRL_EN];
   assign auto_reload = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);

   // Address bits outside [3:2] are decoded by the bridge, not here.
   logic unused_addr;
   assign unused_addr = ^{addr[31:4], addr[1:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      flag_d   = flag_q;

      case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            flag_d  = 1'b0;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (count_q > CNT_W'(1)) begin
               count_d = count_q - CNT_W'(1);
            end else begin
               // Covers COUNT==0 too, so PRESET=0 acts like PRESET=1 and
               // the counter can never wrap.
               count_d = '0;
               flag_d  = 1'b1;
               state_d = ST_INT;
            end
         end
         ST_INT: begin
            if (auto_reload) begin
               flag_d  = 1'b0;
               state_d = ST_LOAD;
            end else begin
               ctrl_d[CTRL_EN] = 1'b0;
               state_d         = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Bus writes are applied after the FSM so a CTRL write overrides the
      // FSM's EN auto-clear and any flag update in the same cycle.
      if (we) begin
         case (reg_sel)
            OFF_CTRL: begin
               ctrl_d = wdata[CTRL_W-1:0];
               flag_d = 1'b0;
            end
            OFF_PRESET: preset_d = wdata[CNT_W-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (reg_sel)
         OFF_CTRL:   rdata = 32'(ctrl_q);
         OFF_PRESET: rdata = 32'(preset_q);
         OFF_COUNT:  rdata = 32'(count_q);
         default:    rdata = '0;
      endcase
   end

   assign irq = flag_q & ctrl_q[CTRL_IM];

endmodule
